// File: rtl/usb2_ts_in_sched_if.sv
// rtl/usb2_ts_in_sched_if.sv - TS source streams and EP3 buffer port of the IN scheduler
interface usb2_ts_in_sched_if;
   logic        enable;
   logic [7:0]  s0_data;
   logic        s0_valid;
   logic        s0_sop;
   logic        s0_ready;
   logic [7:0]  s1_data;
   logic        s1_valid;
   logic        s1_sop;
   logic        s1_ready;
   logic [10:0] buf_in_addr;
   logic [7:0]  buf_in_data;
   logic        buf_in_wren;
   logic        buf_in_ready;
   logic        buf_in_commit;
   logic [10:0] buf_in_commit_len;
   logic        buf_in_commit_ack;
   logic [1:0]  err_sync;
   logic        grant;

   modport master (
      input  enable,
      input  s0_data, s0_valid, s0_sop,
      output s0_ready,
      input  s1_data, s1_valid, s1_sop,
      output s1_ready,
      output buf_in_addr, buf_in_data, buf_in_wren,
      input  buf_in_ready,
      output buf_in_commit, buf_in_commit_len,
      input  buf_in_commit_ack,
      output err_sync, grant
   );

   modport slave (
      output enable,
      output s0_data, s0_valid, s0_sop,
      input  s0_ready,
      output s1_data, s1_valid, s1_sop,
      input  s1_ready,
      input  buf_in_addr, buf_in_data, buf_in_wren,
      output buf_in_ready,
      input  buf_in_commit, buf_in_commit_len,
      output buf_in_commit_ack,
      input  err_sync, grant
   );
endinterface

// File: rtl/usb2_ts_in_sched.sv
// rtl/usb2_ts_in_sched.sv - EP3 transport-stream IN packet scheduler
// Round-robin packet arbiter of two TS sources feeding the EP3 buffer with commit/ack.
module usb2_ts_in_sched #(
   parameter int PKT_LEN       = 188,
   parameter int MAX_LEN       = 1024,
   parameter int FLUSH_TIMEOUT = 60000
) (
   input logic                ext_clk,
   input logic                reset_n,
   usb2_ts_in_sched_if.master bus
);

   localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(FLUSH_TIMEOUT - 1);
   localparam logic [7:0]    IDX_LAST = 8'(PKT_LEN - 1);
   localparam logic [11:0]   PKT_W    = 12'(PKT_LEN);
   localparam logic [11:0]   MAX_W    = 12'(MAX_LEN);

   typedef enum logic [1:0] {IDLE, XFER, COMMIT} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [10:0]   fill;
   logic [7:0]    idx;
   logic [10:0]   pkt_base;
   logic          last;
   logic          grant_q;
   logic [TW-1:0] tmo;
   logic          wren_q;
   logic [10:0]   addr_q;
   logic [7:0]    data_q;
   logic          commit_q;
   logic [10:0]   commit_len_q;
   logic [1:0]    err_q;

   logic          qual0;
   logic          qual1;
   logic          cur_valid;
   logic          cur_sop;
   logic [7:0]    cur_data;
   logic          cur_hold;
   logic [11:0]   fill_inc;

   logic          rdy0;
   logic          rdy1;
   logic          disc0;
   logic          disc1;
   logic          do_grant;
   logic          gnt_src;
   logic          accept;
   logic          rewind;
   logic          pkt_done;
   logic          commit_done;

   assign qual0     = bus.s0_valid & bus.s0_sop;
   assign qual1     = bus.s1_valid & bus.s1_sop;
   assign cur_valid = grant_q ? bus.s1_valid : bus.s0_valid;
   assign cur_sop   = grant_q ? bus.s1_sop   : bus.s0_sop;
   assign cur_data  = grant_q ? bus.s1_data  : bus.s0_data;
   // A new sop inside a packet is refused so it can restart the packet from IDLE.
   assign cur_hold  = cur_sop & (idx != 8'd0);
   assign fill_inc  = {1'b0, fill} + 12'd1;

   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      rdy0        = 1'b0;
      rdy1        = 1'b0;
      disc0       = 1'b0;
      disc1       = 1'b0;
      do_grant    = 1'b0;
      gnt_src     = 1'b0;
      accept      = 1'b0;
      rewind      = 1'b0;
      pkt_done    = 1'b0;
      commit_done = 1'b0;
      case (state)
         IDLE: begin
            disc0 = bus.s0_valid & ~bus.s0_sop;
            disc1 = bus.s1_valid & ~bus.s1_sop;
            rdy0  = disc0;
            rdy1  = disc1;
            if (bus.enable && bus.buf_in_ready && (qual0 || qual1)) begin
               do_grant  = 1'b1;
               gnt_src   = (qual0 && qual1) ? ~last : qual1;
               state_nxt = XFER;
            end else if (fill != 11'd0 && (tmo == TMO_LAST || !bus.enable)) begin
               state_nxt = COMMIT;
            end
         end
         XFER: begin
            if (grant_q) begin
               rdy1 = ~cur_hold;
            end else begin
               rdy0 = ~cur_hold;
            end
            if (cur_valid && cur_hold) begin
               rewind    = 1'b1;
               state_nxt = IDLE;
            end else if (cur_valid) begin
               accept = 1'b1;
               if (idx == IDX_LAST) begin
                  pkt_done  = 1'b1;
                  state_nxt = (fill_inc + PKT_W > MAX_W) ? COMMIT : IDLE;
               end
            end
         end
         COMMIT: begin
            if (commit_q && bus.buf_in_commit_ack) begin
               commit_done = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ext_clk or negedge reset_n) begin
      if (!reset_n) begin
         fill         <= 11'd0;
         idx          <= 8'd0;
         pkt_base     <= 11'd0;
         last         <= 1'b1;
         grant_q      <= 1'b0;
         tmo          <= '0;
         wren_q       <= 1'b0;
         addr_q       <= 11'd0;
         data_q       <= 8'd0;
         commit_q     <= 1'b0;
         commit_len_q <= 11'd0;
         err_q        <= 2'b00;
      end else begin
         wren_q <= 1'b0;
         err_q  <= {disc1, disc0};
         if (do_grant) begin
            grant_q  <= gnt_src;
            pkt_base <= fill;
            idx      <= 8'd0;
         end
         if (accept) begin
            wren_q <= 1'b1;
            addr_q <= fill;
            data_q <= cur_data;
            fill   <= fill + 11'd1;
            idx    <= idx + 8'd1;
         end
         if (rewind) begin
            fill           <= pkt_base;
            err_q[grant_q] <= 1'b1;
         end
         if (pkt_done) begin
            last <= grant_q;
         end
         if (pkt_done || commit_done) begin
            tmo <= '0;
         end else if (state == IDLE && fill != 11'd0 && tmo != TMO_LAST) begin
            tmo <= tmo + 1'b1;
         end
         if (state == COMMIT) begin
            if (commit_done) begin
               commit_q <= 1'b0;
               fill     <= 11'd0;
            end else begin
               commit_q     <= 1'b1;
               commit_len_q <= fill;
            end
         end
      end
   end

   // Gating with reset keeps every output low while reset is held.
   assign bus.s0_ready          = reset_n & rdy0;
   assign bus.s1_ready          = reset_n & rdy1;
   assign bus.buf_in_addr       = addr_q;
   assign bus.buf_in_data       = data_q;
   assign bus.buf_in_wren       = wren_q;
   assign bus.buf_in_commit     = commit_q;
   assign bus.buf_in_commit_len = commit_len_q;
   assign bus.err_sync          = err_q;
   assign bus.grant             = grant_q;

endmodule

// File: tb/tb_usb2_ts_in_sched.sv
// tb/tb_usb2_ts_in_sched.sv - self-checking bench for usb2_ts_in_sched
module tb_usb2_ts_in_sched;

   localparam int FT = 16;

   typedef struct {logic [7:0] data; logic sop;} stim_t;
   typedef struct {logic [10:0] addr; logic [7:0] data; logic grant;} exp_t;
   typedef struct {logic v0; logic s0; logic v1; logic s1; logic r0; logic r1;} vec_t;

   logic clk;
   logic rst_n;
   usb2_ts_in_sched_if bus();

   usb2_ts_in_sched #(.PKT_LEN(188), .MAX_LEN(1024), .FLUSH_TIMEOUT(FT)) dut (
      .ext_clk (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   stim_t q0[$];
   stim_t q1[$];
   exp_t  sb[$];
   int    ec[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wren_cnt = 0;
   int last_wren_cyc = 0;
   int commit_rise_cyc = 0;
   int err_cnt0 = 0;
   int err_cnt1 = 0;
   int ack_delay = 0;
   int commit_hi = 0;
   int held_len = 0;
   bit prev_commit = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic void push_pkt(int src, int seed, int n, int base);
      for (int i = 0; i < n; i++) begin
         stim_t s;
         exp_t  e;
         s.data = 8'(seed + i);
         s.sop  = (i == 0);
         if (src == 0) q0.push_back(s); else q1.push_back(s);
         e.addr  = 11'(base + i);
         e.data  = s.data;
         e.grant = (src != 0);
         sb.push_back(e);
      end
   endfunction

   function automatic void drive();
      if (q0.size() > 0) begin
         bus.s0_valid = 1'b1; bus.s0_data = q0[0].data; bus.s0_sop = q0[0].sop;
      end else begin
         bus.s0_valid = 1'b0; bus.s0_data = 8'h00; bus.s0_sop = 1'b0;
      end
      if (q1.size() > 0) begin
         bus.s1_valid = 1'b1; bus.s1_data = q1[0].data; bus.s1_sop = q1[0].sop;
      end else begin
         bus.s1_valid = 1'b0; bus.s1_data = 8'h00; bus.s1_sop = 1'b0;
      end
   endfunction

   function automatic void monitor();
      if (bus.buf_in_wren) begin
         wren_cnt++;
         last_wren_cyc = cyc;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL write: unexpected write addr %0d data %0h", bus.buf_in_addr, bus.buf_in_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.buf_in_addr !== e.addr || bus.buf_in_data !== e.data || bus.grant !== e.grant) begin
               errors++;
               $display("FAIL write: got addr %0d data %0h grant %0d expected addr %0d data %0h grant %0d",
                        bus.buf_in_addr, bus.buf_in_data, bus.grant, e.addr, e.data, e.grant);
            end
         end
      end
      if (bus.buf_in_commit) begin
         if (!prev_commit) begin
            commit_rise_cyc = cyc;
            held_len = int'(bus.buf_in_commit_len);
            if (ec.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL commit: unexpected commit len %0d", bus.buf_in_commit_len);
            end else begin
               int l;
               l = ec.pop_front();
               chk("commit len", 32'(bus.buf_in_commit_len), l);
            end
         end else begin
            chk("commit len hold", 32'(bus.buf_in_commit_len), held_len);
         end
         commit_hi++;
      end else begin
         commit_hi = 0;
      end
      prev_commit = bus.buf_in_commit;
      bus.buf_in_commit_ack = bus.buf_in_commit && (commit_hi > ack_delay);
      err_cnt0 += int'(bus.err_sync[0]);
      err_cnt1 += int'(bus.err_sync[1]);
   endfunction

   task automatic tick();
      bit a0;
      bit a1;
      #1;
      a0 = bus.s0_valid && bus.s0_ready;
      a1 = bus.s1_valid && bus.s1_ready;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (a0 && q0.size() > 0) q0.delete(0);
      if (a1 && q1.size() > 0) q1.delete(0);
      monitor();
      drive();
   endtask

   task automatic run_until_done(string name, int max);
      int n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && ec.size() == 0
               && !bus.buf_in_commit) && n < max) begin
         tick();
         n++;
      end
      chk({name, " completes in budget"}, 32'(n < max), 1);
   endtask

   function automatic void chk_zero(string tag);
      chk({tag, " addr"},       32'(bus.buf_in_addr), 0);
      chk({tag, " data"},       32'(bus.buf_in_data), 0);
      chk({tag, " wren"},       32'(bus.buf_in_wren), 0);
      chk({tag, " commit"},     32'(bus.buf_in_commit), 0);
      chk({tag, " commit_len"}, 32'(bus.buf_in_commit_len), 0);
      chk({tag, " err_sync"},   32'(bus.err_sync), 0);
      chk({tag, " grant"},      32'(bus.grant), 0);
      chk({tag, " s0_ready"},   32'(bus.s0_ready), 0);
      chk({tag, " s1_ready"},   32'(bus.s1_ready), 0);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      q0.delete(); q1.delete(); sb.delete(); ec.delete();
      drive();
      bus.enable = 1'b1;
      bus.buf_in_ready = 1'b1;
      bus.buf_in_commit_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      prev_commit = 1'b0; commit_hi = 0; err_cnt0 = 0; err_cnt1 = 0; ack_delay = 0;
   endtask

   initial begin
      vec_t vecs[7];
      int   w0;
      vecs[0] = '{v0:0, s0:0, v1:0, s1:0, r0:0, r1:0};
      vecs[1] = '{v0:1, s0:0, v1:0, s1:0, r0:1, r1:0};
      vecs[2] = '{v0:1, s0:1, v1:0, s1:0, r0:0, r1:0};
      vecs[3] = '{v0:0, s0:0, v1:1, s1:0, r0:0, r1:1};
      vecs[4] = '{v0:1, s0:0, v1:1, s1:0, r0:1, r1:1};
      vecs[5] = '{v0:1, s0:1, v1:1, s1:0, r0:0, r1:1};
      vecs[6] = '{v0:0, s0:1, v1:0, s1:1, r0:0, r1:0};

      rst_n = 1'b0;
      bus.enable = 1'b0; bus.buf_in_ready = 1'b0; bus.buf_in_commit_ack = 1'b0;
      drive();
      @(negedge clk);
      do_reset();

      // IDLE ready decode: applied between edges and withdrawn before the next edge.
      for (int i = 0; i < 7; i++) begin
         bus.s0_valid = vecs[i].v0; bus.s0_sop = vecs[i].s0;
         bus.s1_valid = vecs[i].v1; bus.s1_sop = vecs[i].s1;
         #1;
         chk($sformatf("idle vec%0d s0_ready", i), 32'(bus.s0_ready), 32'(vecs[i].r0));
         chk($sformatf("idle vec%0d s1_ready", i), 32'(bus.s1_ready), 32'(vecs[i].r1));
         drive();
         @(negedge clk);
      end

      // Five back-to-back packets from source 0, commit 940 with a slow ack, sixth restarts at 0.
      do_reset();
      ack_delay = 3;
      for (int k = 0; k < 5; k++) push_pkt(0, 16 * k + 1, 188, 188 * k);
      push_pkt(0, 8'h60, 188, 0);
      ec.push_back(940);
      ec.push_back(188);
      drive();
      run_until_done("single source", 3000);
      chk("single source err0", err_cnt0, 0);
      chk("single source err1", err_cnt1, 0);

      // Both sources always valid: grants alternate starting with source 0.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         push_pkt(0, 16 * k + 1, 188, 376 * k);
         if (k < 2) push_pkt(1, 8'h80 + 16 * k, 188, 376 * k + 188);
      end
      push_pkt(1, 8'hA0, 188, 0);
      ec.push_back(940);
      ec.push_back(188);
      drive();
      run_until_done("alternating", 3000);
      chk("alternating err1", err_cnt1, 0);

      // Flush timeout after a single packet.
      do_reset();
      push_pkt(1, 8'h33, 188, 0);
      ec.push_back(188);
      drive();
      run_until_done("timeout", 1000);
      chk("flush latency", commit_rise_cyc - last_wren_cyc, FT + 1);

      // Framing error: sop at byte 100 of source 1 rewinds to its packet base.
      do_reset();
      push_pkt(0, 8'h05, 188, 0);
      push_pkt(1, 8'h80, 100, 188);
      push_pkt(1, 8'hC0, 188, 188);
      ec.push_back(376);
      drive();
      run_until_done("rewind", 2000);
      chk("rewind err1 pulses", err_cnt1, 1);
      chk("rewind err0 pulses", err_cnt0, 0);

      // Buffer busy holds off both sources; raising ready grants on the next edge.
      do_reset();
      bus.buf_in_ready = 1'b0;
      push_pkt(0, 8'h11, 188, 0);
      push_pkt(1, 8'h91, 188, 188);
      ec.push_back(376);
      drive();
      w0 = wren_cnt;
      repeat (10) tick();
      chk("busy writes", wren_cnt - w0, 0);
      #1;
      chk("busy s0_ready", 32'(bus.s0_ready), 0);
      chk("busy s1_ready", 32'(bus.s1_ready), 0);
      bus.buf_in_ready = 1'b1;
      tick();
      #1;
      chk("grant after ready s0_ready", 32'(bus.s0_ready), 1);
      chk("grant after ready s1_ready", 32'(bus.s1_ready), 0);
      run_until_done("busy", 2000);
      begin
         stim_t s;
         s.data = 8'h5A; s.sop = 1'b0;
         q1.push_back(s);
      end
      drive();
      repeat (3) tick();
      chk("stray byte consumed", q1.size(), 0);
      chk("stray byte err1", err_cnt1, 1);

      // Enable drop with two packets pending: commit 376 and no further grants.
      do_reset();
      push_pkt(0, 8'h21, 188, 0);
      push_pkt(0, 8'h41, 188, 188);
      ec.push_back(376);
      drive();
      for (int n = 0; n < 1000 && sb.size() > 0; n++) tick();
      chk("enable drop writes done", sb.size(), 0);
      bus.enable = 1'b0;
      for (int i = 0; i < 188; i++) begin
         stim_t s;
         s.data = 8'(i); s.sop = (i == 0);
         q0.push_back(s);
      end
      w0 = wren_cnt;
      repeat (40) tick();
      chk("enable drop commit seen", ec.size(), 0);
      chk("enable drop no grant", q0.size(), 188);
      chk("enable drop no writes", wren_cnt - w0, 0);

      // Reset in the middle of a packet.
      do_reset();
      push_pkt(0, 8'h71, 188, 0);
      drive();
      repeat (60) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async reset");
      q0.delete(); sb.delete(); ec.delete();
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      prev_commit = 1'b0; commit_hi = 0;
      push_pkt(0, 8'h77, 188, 0);
      ec.push_back(188);
      drive();
      run_until_done("after reset", 1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
